// File: rtl/vecchk_pkg.sv
// Shared types and helpers for the vector_checker self-test stage.
package vecchk_pkg;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  // Upper bounds for the truth-table slicer; tables and outputs beyond these are unsupported.
  localparam int MAX_TBL_W = 1024;
  localparam int MAX_OUT_W = 32;

  function automatic int nvec_of(input int nin);
    return 1 << nin;
  endfunction

  function automatic int err_w(input int nin);
    return $clog2((1 << nin) + 1);
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Expected response of vector i, zero-extended to MAX_OUT_W.
  function automatic logic [MAX_OUT_W-1:0] exp_of(input logic [MAX_TBL_W-1:0] tbl,
                                                  input int i, input int nout);
    logic [MAX_OUT_W-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_OUT_W; b++)
      if (b < nout) r[b] = tbl[i*nout + b];
    return r;
  endfunction

endpackage

// File: rtl/vecchk_settle_timer.sv
// SETTLE-cycle down-counter: load on entry to APPLY, expire_o high in the last held cycle.
module vecchk_settle_timer
  import vecchk_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int TW = cnt_w(SETTLE + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                     cnt_d = TW'(SETTLE - 1);
    else if (en_i && cnt_q != '0)   cnt_d = cnt_q - TW'(1);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/vector_checker.sv
// On-chip truth-table checker: walks all NIN-bit vectors, compares DUT output to EXPECTED.
// Optional first-mismatch log is built when VECCHK_ERRLOG_EN is defined.
module vector_checker
  import vecchk_pkg::*;
#(
  parameter int NIN    = 3,
  parameter int NOUT   = 1,
  parameter int SETTLE = 1,
  parameter logic [(2**NIN)*NOUT-1:0] EXPECTED = 8'b0011_0001
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [NIN-1:0]          dut_in,
  input  logic [NOUT-1:0]         dut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [err_w(NIN)-1:0]   err_count,
  output logic [NIN-1:0]          first_err_idx,
  output logic [NOUT-1:0]         first_err_val
);

  localparam int NVEC = nvec_of(NIN);
  localparam int EW   = err_w(NIN);
  localparam logic [NIN-1:0] IDX_LAST = NIN'(NVEC - 1);

  state_t          state_q, state_d;
  logic [NIN-1:0]  idx_q, idx_d;
  logic [EW-1:0]   err_q, err_d;
  logic            done_q, done_d, pass_q, pass_d;
  logic            tmr_load, tmr_en, tmr_expire;
  logic [MAX_OUT_W-1:0] exp_full;
  logic            mismatch, run_start;

  vecchk_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  assign exp_full  = exp_of(MAX_TBL_W'(EXPECTED), int'(idx_q), NOUT);
  assign mismatch  = (MAX_OUT_W'(dut_out) != exp_full);
  assign run_start = start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    done_d   = done_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d  = APPLY;
        idx_d    = '0;
        err_d    = '0;
        done_d   = 1'b0;
        pass_d   = 1'b0;
        tmr_load = 1'b1;
      end
      APPLY: begin
        tmr_en = 1'b1;
        if (tmr_expire) state_d = CHECK;
      end
      CHECK: begin
        err_d = err_q + EW'(mismatch);
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d  = APPLY;
          idx_d    = idx_q + NIN'(1);
          tmr_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end

  // idx is zero in IDLE and frozen in DONE, so it doubles as the DUT drive.
  assign dut_in    = idx_q;
  assign busy      = (state_q == APPLY) || (state_q == CHECK);
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

`ifdef VECCHK_ERRLOG_EN
  logic [NIN-1:0]  fidx_q;
  logic [NOUT-1:0] fval_q;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fidx_q <= '0;
      fval_q <= '0;
    end else if (run_start) begin
      fidx_q <= '0;
      fval_q <= '0;
    end else if (state_q == CHECK && mismatch && err_q == '0) begin
      fidx_q <= idx_q;
      fval_q <= dut_out;
    end

  assign first_err_idx = fidx_q;
  assign first_err_val = fval_q;
`else
  assign first_err_idx = '0;
  assign first_err_val = '0;
`endif

endmodule

// File: tb/tb_vector_checker.sv
// Scoreboard bench: two checkers (SETTLE=1 and SETTLE=3) driving a sillyfunction model.
module tb_vector_checker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int mode = 0;

  typedef struct {
    int         err;
    logic       pass;
    logic [2:0] fidx;
    logic       fval;
    int         cyc;
  } exp_t;

  exp_t qa[$], qb[$];
  int a_c0 = -100, b_c0 = -100;

  logic       start_a, busy_a, done_a, pass_a, dout_a, fval_a;
  logic [2:0] din_a, fidx_a;
  logic [3:0] err_a;
  logic       start_b, busy_b, done_b, pass_b, dout_b, fval_b;
  logic [2:0] din_b, fidx_b;
  logic [3:0] err_b;

  // mode 0 correct, 1 y stuck-at-0, 2 y inverted, 3 y flipped at vector 7 only
  function automatic logic model(input logic [2:0] v, input int m);
    logic y;
    y = (~v[1] & ~v[0]) | (v[2] & ~v[1]);
    case (m)
      1: y = 1'b0;
      2: y = ~y;
      3: if (v == 3'd7) y = ~y;
      default: ;
    endcase
    return y;
  endfunction

  assign dout_a = model(din_a, mode);
  assign dout_b = model(din_b, mode);

  vector_checker #(.NIN(3), .NOUT(1), .SETTLE(1), .EXPECTED(8'b0011_0001)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .dut_in(din_a), .dut_out(dout_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err_idx(fidx_a), .first_err_val(fval_a));

  vector_checker #(.NIN(3), .NOUT(1), .SETTLE(3), .EXPECTED(8'b0011_0001)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .dut_in(din_b), .dut_out(dout_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_idx(fidx_b), .first_err_val(fval_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input int err, input logic [2:0] fi, input logic fv, input int lat);
    exp_t e;
    e.err  = err;
    e.pass = (err == 0);
`ifdef VECCHK_ERRLOG_EN
    e.fidx = fi;
    e.fval = fv;
`else
    e.fidx = 3'd0;
    e.fval = 1'b0;
`endif
    e.cyc  = cyc + lat;
    return e;
  endfunction

  // Monitor: per-cycle dut_in walk while busy, scoreboard pop on each rising done.
  logic pa = 1'b0, pb = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy_a) chk("a_dut_in", 32'(din_a), 32'((cyc - a_c0 - 1) / 2));
    if (busy_b) chk("b_dut_in", 32'(din_b), 32'((cyc - b_c0 - 1) / 4));
    if (done_a && !pa) begin
      if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_done_cycle", cyc, e.cyc);
        chk("a_err_count", 32'(err_a), e.err);
        chk("a_pass", 32'(pass_a), 32'(e.pass));
        chk("a_first_idx", 32'(fidx_a), 32'(e.fidx));
        chk("a_first_val", 32'(fval_a), 32'(e.fval));
        chk("a_busy_in_done", 32'(busy_a), 0);
        chk("a_dut_in_done", 32'(din_a), 7);
      end
    end
    if (done_b && !pb) begin
      if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_done_cycle", cyc, e.cyc);
        chk("b_err_count", 32'(err_b), e.err);
        chk("b_pass", 32'(pass_b), 32'(e.pass));
        chk("b_first_idx", 32'(fidx_b), 32'(e.fidx));
        chk("b_first_val", 32'(fval_b), 32'(e.fval));
      end
    end
    pa = done_a;
    pb = done_b;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_a(input int err, input logic [2:0] fi, input logic fv);
    qa.push_back(mk(err, fi, fv, 17));
    a_c0 = cyc;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
  endtask

  task automatic run_b(input int err, input logic [2:0] fi, input logic fv);
    qb.push_back(mk(err, fi, fv, 33));
    b_c0 = cyc;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 60) begin
      tick(1);
      n++;
    end
    tick(1);
    chk(name, 32'(qa.size() + qb.size()), 0);
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_a), 0);
    chk({tag, "_done"}, 32'(done_a), 0);
    chk({tag, "_pass"}, 32'(pass_a), 0);
    chk({tag, "_err"},  32'(err_a),  0);
    chk({tag, "_din"},  32'(din_a),  0);
    chk({tag, "_fidx"}, 32'(fidx_a), 0);
    chk({tag, "_fval"}, 32'(fval_a), 0);
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    tick(3);
    chk_a_zero("reset");
    chk("reset_b_done", 32'(done_b), 0);
    reset = 1'b0;
    tick(2);

    mode = 0; run_a(0, 3'd0, 1'b0); drain("t1_drain");
    mode = 1; run_a(3, 3'd0, 1'b0); drain("t2_drain");
    mode = 2; run_a(8, 3'd0, 1'b0); drain("t3_drain");
    mode = 3; run_a(1, 3'd7, 1'b1); drain("t3b_drain");

    // start mid-run is ignored; restart from DONE clears results next cycle
    mode = 0; run_a(0, 3'd0, 1'b0);
    tick(4);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    drain("t4_drain");
    chk("t4_done_held", 32'(done_a), 1);
    run_a(0, 3'd0, 1'b0);
    chk("t4_done_drop", 32'(done_a), 0);
    chk("t4_pass_drop", 32'(pass_a), 0);
    chk("t4_busy", 32'(busy_a), 1);
    drain("t4_rerun_drain");

    // reset during APPLY of vector 3, with a recorded mismatch pending
    mode = 1;
    a_c0 = cyc;
    start_a = 1'b1; tick(1); start_a = 1'b0;
    tick(6);
    chk("t5_din_pre", 32'(din_a), 3);
    chk("t5_busy_pre", 32'(busy_a), 1);
    chk("t5_err_pre", 32'(err_a), 1);
    reset = 1'b1;
    #1;
    chk_a_zero("t5_reset");
    tick(1);
    reset = 1'b0;
    tick(1);
    mode = 0; run_a(0, 3'd0, 1'b0); drain("t5_drain");

    mode = 0; run_b(0, 3'd0, 1'b0); drain("t6_drain");
    mode = 1; run_b(3, 3'd0, 1'b0); drain("t6b_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
